// File: rtl/des_ctrl_pkg.sv
// Shared types, constants and key helpers for the DES request scheduler.
// Contents: FSM state type, last-round constant, block/key widths,
//           key64_to_56 (drop parity bits), key_odd_parity (per-byte odd parity).
package des_ctrl_pkg;

    localparam int unsigned DES_BLK_W  = 64;
    localparam int unsigned DES_KEY_W  = 56;
    localparam int unsigned DES_RND_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [DES_RND_W-1:0] DES_LAST_ROUND = 4'd15;

    // Keep the upper seven bits of every byte: {k[63:57], k[55:49], ..., k[7:1]}.
    function automatic logic [DES_KEY_W-1:0] key64_to_56(input logic [DES_BLK_W-1:0] k);
        logic [DES_KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*7 +: 7] = k[i*8+1 +: 7];
        end
        return r;
    endfunction

    // True when every byte of the key carries odd parity.
    function automatic logic key_odd_parity(input logic [DES_BLK_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ok = ok & (^k[i*8 +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req          - request vector
//        last_grant   - ID granted last (held by the caller)
//        en           - arbitration enable; no grant when low
//        grant_onehot - one-hot grant (or zero)
//        grant_id     - binary ID of the winner (0 when no grant)
module des_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    input  logic             en,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Scan starting just after last_grant, wrapping, first requester wins.
    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        found        = 1'b0;
        idx          = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = ID_W'((32'(last_grant) + off) % N_REQ);
            if (en && !found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_id          = idx;
            end
        end
    end

endmodule

// File: rtl/des_req_sched.sv
// Time-shares one iterative 16-round DES core among N_REQ AXI-stream requesters.
// Round-robin grant, latch block/key/direction, step des_round 0..15, capture
// des_out and return it on m_* tagged with the requester ID.
// Ports: clk, rst (sync, active-high)
//        s_tdata/s_tdecrypt/s_tvalid/s_tready/req_key - per-requester inputs
//        m_tdata/m_tdest/m_terr/m_tvalid/m_tready     - result stream
//        des_key/des_decrypt/des_round/des_in/des_out - DES core interface
//        busy - high whenever the FSM is not idle
// Build option: define DES_KEY_PARITY_EN to reject keys with bad byte parity
//               (result 0 with m_terr=1); otherwise parity is ignored and m_terr stays 0.
module des_req_sched
    import des_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0][DES_BLK_W-1:0] s_tdata,
    input  logic [N_REQ-1:0]              s_tdecrypt,
    input  logic [N_REQ-1:0]              s_tvalid,
    output logic [N_REQ-1:0]              s_tready,
    input  logic [N_REQ-1:0][DES_BLK_W-1:0] req_key,
    output logic [DES_BLK_W-1:0]          m_tdata,
    output logic [ID_W-1:0]               m_tdest,
    output logic                          m_terr,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DES_KEY_W-1:0]          des_key,
    output logic                          des_decrypt,
    output logic [DES_RND_W-1:0]          des_round,
    output logic [DES_BLK_W-1:0]          des_in,
    input  logic [DES_BLK_W-1:0]          des_out,
    output logic                          busy
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [N_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]   grant_id;
    logic              grant_fire;
    logic              grant_key_bad;
    logic              key_bad;

    des_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req          (s_tvalid),
        .last_grant   (last_grant),
        .en           (state == ST_IDLE),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id)
    );

    // Ready is the arbiter's grant itself, so it is combinational from s_tvalid.
    assign s_tready   = grant_onehot;
    assign grant_fire = |grant_onehot;

`ifdef DES_KEY_PARITY_EN
    assign grant_key_bad = !key_odd_parity(req_key[grant_id]);
`else
    assign grant_key_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A rejected key bypasses RUN and spends one cycle in
    // CAPT to load the error result, so m_tvalid rises two cycles after grant.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_fire) state_nxt = grant_key_bad ? ST_CAPT : ST_RUN;
            ST_RUN:  if (des_round == DES_LAST_ROUND) state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_OUT;
            ST_OUT:  if (m_tready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job latch, round counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            des_in      <= '0;
            des_key     <= '0;
            des_decrypt <= 1'b0;
            des_round   <= '0;
            m_tdata     <= '0;
            m_tdest     <= '0;
            m_terr      <= 1'b0;
            m_tvalid    <= 1'b0;
            busy        <= 1'b0;
            key_bad     <= 1'b0;
            last_grant  <= ID_W'(N_REQ - 1);
        end else begin
            busy <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        des_in      <= s_tdata[grant_id];
                        des_decrypt <= s_tdecrypt[grant_id];
                        des_key     <= key64_to_56(req_key[grant_id]);
                        des_round   <= '0;
                        m_tdest     <= grant_id;
                        last_grant  <= grant_id;
                        key_bad     <= grant_key_bad;
                    end
                end
                ST_RUN: begin
                    // Saturates at the last round; never wraps.
                    if (des_round != DES_LAST_ROUND) begin
                        des_round <= des_round + 4'd1;
                    end
                end
                ST_CAPT: begin
                    m_tdata  <= key_bad ? '0 : des_out;
                    m_terr   <= key_bad;
                    m_tvalid <= 1'b1;
                end
                ST_OUT: begin
                    if (m_tready) begin
                        m_tvalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_req_sched.sv
module tb_des_req_sched;

    logic              clk;
    logic              rst;
    logic [1:0][63:0]  s_tdata;
    logic [1:0]        s_tdecrypt;
    logic [1:0]        s_tvalid;
    logic [1:0]        s_tready;
    logic [1:0][63:0]  req_key;
    logic [63:0]       m_tdata;
    logic              m_tdest;
    logic              m_terr;
    logic              m_tvalid;
    logic              m_tready;
    logic [55:0]       des_key;
    logic              des_decrypt;
    logic [3:0]        des_round;
    logic [63:0]       des_in;
    logic [63:0]       des_out;
    logic              busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KEY_GOOD   = 64'h133457799BBCDFF1;
    localparam logic [55:0] KEY56_GOOD = 56'h12695BC9B7B7F8;
    localparam logic [63:0] KEY_BAD    = 64'h0023456789ABCDEF;
    localparam logic [55:0] KEY56_BAD  = 56'h00451338957377;
    localparam logic [63:0] PT         = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT         = 64'h85E813540F0AB405;

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert (64'(obs) === 64'(exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, 64'(obs), 64'(exp)); \
        end \
    end

    des_req_sched #(.N_REQ(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tdecrypt  (s_tdecrypt),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .req_key     (req_key),
        .m_tdata     (m_tdata),
        .m_tdest     (m_tdest),
        .m_terr      (m_terr),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .des_key     (des_key),
        .des_decrypt (des_decrypt),
        .des_round   (des_round),
        .des_in      (des_in),
        .des_out     (des_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: known FIPS vector pair, otherwise a simple keyed mix.
    function automatic logic [63:0] core_f(input logic [63:0] d, input logic [55:0] k, input logic dec);
        if (!dec && d == PT && k == KEY56_GOOD) return CT;
        if (dec && d == CT && k == KEY56_GOOD) return PT;
        return d ^ {8'h5A, k} ^ {64{dec}};
    endfunction

    // Result only valid the cycle after round 15 was presented.
    always @(posedge clk)
        des_out <= (des_round == 4'd15) ? core_f(des_in, des_key, des_decrypt) : 64'hBAD0BAD0BAD0BAD0;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot0(s_tready)) else begin
                errors++;
                $error("FAIL s_tready_onehot observed=%b expected=at most one bit", s_tready);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and complete its handshake; returns in cycle T+1.
    task automatic start_job(input logic id, input logic [63:0] d, input logic dec, input logic [63:0] k);
        int c;
        s_tdata[id]    = d;
        s_tdecrypt[id] = dec;
        req_key[id]    = k;
        s_tvalid[id]   = 1'b1;
        #1;
        c = 0;
        while (!s_tready[id] && c < 100) begin
            tick();
            c++;
        end
        `CHK("grant", s_tready[id], 1'b1)
        @(posedge clk);
        #1;
        s_tvalid[id] = 1'b0;
    endtask

    // Called in cycle T+1: check latched job, latency, result and release.
    task automatic finish_job(input logic id, input logic [63:0] d, input logic dec,
                              input logic [55:0] exp_key, input logic [63:0] exp_data,
                              input logic exp_err, input int exp_lat);
        int n;
        `CHK("des_key", des_key, exp_key)
        `CHK("des_in", des_in, d)
        `CHK("des_decrypt", des_decrypt, dec)
        `CHK("busy_run", busy, 1'b1)
        `CHK("round_first", des_round, 4'd0)
        n = 1;
        while (!m_tvalid && n < 60) begin
            tick();
            n++;
            if (n == 16 && exp_lat == 18) `CHK("round_last", des_round, 4'd15)
        end
        `CHK("latency", n, exp_lat)
        `CHK("m_tdata", m_tdata, exp_data)
        `CHK("m_tdest", m_tdest, id)
        `CHK("m_terr", m_terr, exp_err)
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        `CHK("m_tvalid_drop", m_tvalid, 1'b0)
        `CHK("busy_idle", busy, 1'b0)
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        s_tdata    = '0;
        s_tdecrypt = '0;
        s_tvalid   = '0;
        req_key    = '0;
        m_tready   = 1'b0;
        repeat (3) tick();

        // Reset values
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_m_tvalid", m_tvalid, 1'b0)
        `CHK("rst_m_tdata", m_tdata, 64'h0)
        `CHK("rst_m_tdest", m_tdest, 1'b0)
        `CHK("rst_m_terr", m_terr, 1'b0)
        `CHK("rst_des_round", des_round, 4'd0)
        `CHK("rst_des_in", des_in, 64'h0)
        `CHK("rst_des_key", des_key, 56'h0)
        rst = 1'b0;
        tick();

        // 1: single encrypt on requester 0
        start_job(1'b0, PT, 1'b0, KEY_GOOD);
        finish_job(1'b0, PT, 1'b0, KEY56_GOOD, CT, 1'b0, 18);

        // 2: decrypt on requester 1
        start_job(1'b1, CT, 1'b1, KEY_GOOD);
        finish_job(1'b1, CT, 1'b1, KEY56_GOOD, PT, 1'b0, 18);

        // 3: both requesters valid for six jobs; grants alternate from 0
        s_tdata[0] = PT; s_tdecrypt[0] = 1'b0; req_key[0] = KEY_GOOD;
        s_tdata[1] = CT; s_tdecrypt[1] = 1'b1; req_key[1] = KEY_GOOD;
        s_tvalid = 2'b11;
        for (int j = 0; j < 6; j++) begin
            n = 0;
            while (!m_tvalid && n < 60) begin
                tick();
                n++;
            end
            `CHK("rr_m_tvalid", m_tvalid, 1'b1)
            `CHK("rr_m_tdest", m_tdest, j % 2)
            `CHK("rr_m_tdata", m_tdata, (j % 2 == 0) ? CT : PT)
            if (j == 5) s_tvalid = 2'b00;
            m_tready = 1'b1;
            tick();
            m_tready = 1'b0;
        end

        // 4: backpressure for 10 cycles with requester 1 waiting
        start_job(1'b0, PT, 1'b0, KEY_GOOD);
        s_tdata[1] = CT; s_tdecrypt[1] = 1'b1; req_key[1] = KEY_GOOD;
        s_tvalid[1] = 1'b1;
        n = 0;
        while (!m_tvalid && n < 60) begin
            tick();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            `CHK("bp_m_tvalid", m_tvalid, 1'b1)
            `CHK("bp_m_tdata", m_tdata, CT)
            `CHK("bp_m_tdest", m_tdest, 1'b0)
            `CHK("bp_s_tready", s_tready, 2'b00)
            tick();
        end
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        `CHK("bp_release_ready", s_tready, 2'b10)
        start_job(1'b1, CT, 1'b1, KEY_GOOD);
        finish_job(1'b1, CT, 1'b1, KEY56_GOOD, PT, 1'b0, 18);

        // 5: reset in round 7, then re-present
        start_job(1'b0, PT, 1'b0, KEY_GOOD);
        repeat (7) tick();
        `CHK("mid_round", des_round, 4'd7)
        rst = 1'b1;
        tick();
        `CHK("mid_rst_busy", busy, 1'b0)
        `CHK("mid_rst_m_tvalid", m_tvalid, 1'b0)
        `CHK("mid_rst_round", des_round, 4'd0)
        rst = 1'b0;
        tick();
        `CHK("mid_rst_no_output", m_tvalid, 1'b0)
        start_job(1'b0, PT, 1'b0, KEY_GOOD);
        finish_job(1'b0, PT, 1'b0, KEY56_GOOD, CT, 1'b0, 18);

        // 6: key with even parity in byte 7
        start_job(1'b1, PT, 1'b0, KEY_BAD);
`ifdef DES_KEY_PARITY_EN
        finish_job(1'b1, PT, 1'b0, KEY56_BAD, 64'h0, 1'b1, 2);
`else
        finish_job(1'b1, PT, 1'b0, KEY56_BAD, 64'h5B230074B13EBE98, 1'b0, 18);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
